lsr_window_feeder: RTL and testbench
====================================

// Module: lsr_window_feeder
// PURPOSE
//  Producer side of the LSR fitter interface. Takes a streamed sample channel (valid/ready) and keeps a
//  sliding window of DATA_SIZE signed 16-bit samples. Launches the fitter with a one-cycle start pulse and
//  holds the window stable until the fitter returns done. Launches once the first window is full, then
//  again after every `shift` new samples.
// PARAMETERS
//  DATA_SIZE   7    window length in samples (>=2); must match the fitter's DATA_SIZE
//  SHIFT_W     16   width of the shift port and of the internal new-sample counter
// PORTS
//  clk        in   1             single clock, all state on rising edge
//  rst_n      in   1             asynchronous, active-low reset
//  in_data    in   16 signed     incoming sample
//  in_valid   in   1             in_data is valid this cycle
//  in_ready   out  1             feeder accepts in_data this cycle (transfer = in_valid & in_ready)
//  shift      in   SHIFT_W       new samples between launches; sampled once per window, at launch
//  flush      in   1             synchronous: discard window contents, return to FILL
//  win_data   out  DATA_SIZE*16  window, flattened; slot j = win_data[16*j +: 16], slot 0 = oldest
//  win_start  out  1             one-cycle launch pulse to the fitter
//  win_done   in   1             fitter finished with the current window (level or pulse)
//  busy       out  1             a window is with the fitter
//  win_count  out  16            number of launches, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (rst_n=0, async): all outputs 0, win_data all 0, state FILL, counters 0, latched shift = 1.
//  Accepting a sample: the window shifts toward slot 0. Slot j takes slot j+1, the old slot 0 is dropped,
//    and slot DATA_SIZE-1 takes in_data. win_data updates on the cycle after the transfer edge.
//  FSM:
//   FILL    in_ready=1. fill_cnt counts transfers. The transfer that makes fill_cnt=DATA_SIZE -> LAUNCH.
//   COLLECT in_ready=1. new_cnt counts transfers. The transfer that makes new_cnt=shift_l -> LAUNCH.
//   LAUNCH  in_ready=0. win_start=1 for exactly this cycle. Latch shift into shift_l, win_count++,
//           new_cnt=0 -> BUSY.
//   BUSY    in_ready=0, busy=1, win_data frozen. win_done=1 -> COLLECT (in_ready=1 from the next cycle).
//  Latency: last sample's transfer edge -> win_start high next cycle; win_data already valid then.
//  Shift latch: shift==0 -> 1; shift>DATA_SIZE -> DATA_SIZE (no overlap, no skipped samples).
//  win_done sampled only in BUSY; ignored in every other state (no effect, no error).
//  flush: highest priority after reset. Any state -> FILL next cycle; fill_cnt=new_cnt=0; win_data not
//    cleared but stale. win_count kept. If flush arrives in BUSY, the fitter result is orphaned.
//  in_valid & ~in_ready: sample is not consumed; upstream holds it (standard valid/ready, no drop).
//  flush and a transfer in the same cycle: the sample is discarded.
//  win_start is never asserted twice without an intervening BUSY->COLLECT.
//  Arithmetic: fill_cnt range 0..DATA_SIZE, width $clog2(DATA_SIZE+1). new_cnt and shift_l SHIFT_W wide,
//    unsigned compare.
// STRUCTURE
//  Package lsr_pkg: SAMPLE_W=16, typedef logic signed [15:0] sample_t, feeder state enum
//    {FILL,COLLECT,LAUNCH,BUSY}. Shared with the fitter so DATA_SIZE/sample types match.
//  One sub-module, lsr_window_sreg: DATA_SIZE x sample_t shift register with shift_en and flat output.
//  FSM, counters and the shift latch stay in the top.
// TESTING
//  1 Reset, DATA_SIZE=7, stream 1..7 back-to-back -> win_start once, one cycle after the 7th transfer;
//    slots 0..6 = 1..7; win_count=1.
//  2 shift=2, win_done after 5 cycles, stream 8,9 -> second launch with slots = 3..9; in_ready=0 while
//    busy; 8 is held and not lost.
//  3 shift=0 -> behaves as 1 (launch after each sample). shift=20 -> behaves as 7 (fully new window).
//  4 flush mid-BUSY, then stream 7 samples -> no launch until the 7th; win_done ignored outside BUSY;
//    win_count unchanged by flush.
//  5 rst_n low mid-COLLECT (asynchronous, between edges) -> outputs 0 immediately; refill needs 7 samples.
//  6 win_count at 0xFFFF + one launch -> 0; random valid gaps -> the window always equals the last 7
//    accepted samples (scoreboard).

Source files
------------

// File: rtl/lsr_pkg.sv
`default_nettype none
// ============================================================================
// lsr_pkg : sample type and feeder state encoding shared by feeder and fitter
// Rev 1.0
// ============================================================================
package lsr_pkg;

   localparam int SAMPLE_W = 16;

   typedef logic signed [SAMPLE_W-1:0] sample_t;

   typedef enum logic [1:0] {
      FILL    = 2'd0,
      COLLECT = 2'd1,
      LAUNCH  = 2'd2,
      BUSY    = 2'd3
   } feeder_state_e;

endpackage
`default_nettype wire

// File: rtl/lsr_window_sreg.sv
`default_nettype none
// ============================================================================
// lsr_window_sreg : DATA_SIZE-deep sample shift register, slot 0 = oldest
// Rev 1.0
// ============================================================================
module lsr_window_sreg
   import lsr_pkg::*;
#(
   parameter int DATA_SIZE = 7
)
(
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            shift_en,
   input  sample_t                         din,
   output logic [DATA_SIZE*SAMPLE_W-1:0]   win_flat
);

   sample_t slot_q [DATA_SIZE];
   sample_t slot_d [DATA_SIZE];

   always_comb begin
      for (int j = 0; j < DATA_SIZE; j++) begin
         slot_d[j] = slot_q[j];
      end
      if (shift_en) begin
         for (int j = 0; j < DATA_SIZE - 1; j++) begin
            slot_d[j] = slot_q[j+1];
         end
         slot_d[DATA_SIZE-1] = din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < DATA_SIZE; j++) begin
            slot_q[j] <= '0;
         end
      end else begin
         for (int j = 0; j < DATA_SIZE; j++) begin
            slot_q[j] <= slot_d[j];
         end
      end
   end

   generate
      for (genvar j = 0; j < DATA_SIZE; j++) begin : g_slot
         assign win_flat[SAMPLE_W*j +: SAMPLE_W] = slot_q[j];
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/lsr_window_feeder.sv
`default_nettype none
// ============================================================================
// lsr_window_feeder : streams samples into a sliding window and launches the
//                     LSR fitter once per window; holds the window while busy
// Rev 1.0
// ============================================================================
module lsr_window_feeder
   import lsr_pkg::*;
#(
   parameter int DATA_SIZE = 7,
   parameter int SHIFT_W   = 16
)
(
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic signed [SAMPLE_W-1:0]      in_data,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [SHIFT_W-1:0]              shift,
   input  logic                            flush,
   output logic [DATA_SIZE*SAMPLE_W-1:0]   win_data,
   output logic                            win_start,
   input  logic                            win_done,
   output logic                            busy,
   output logic [15:0]                     win_count
);

   localparam int                 FILL_W    = $clog2(DATA_SIZE + 1);
   localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(DATA_SIZE);
   localparam logic [SHIFT_W-1:0] SHIFT_MAX = SHIFT_W'(DATA_SIZE);

   feeder_state_e       state_q,     state_d;
   logic [FILL_W-1:0]   fill_cnt_q,  fill_cnt_d;
   logic [SHIFT_W-1:0]  new_cnt_q,   new_cnt_d;
   logic [SHIFT_W-1:0]  shift_l_q,   shift_l_d;
   logic [15:0]         win_count_q, win_count_d;
   logic                in_ready_q,  in_ready_d;
   logic                win_start_q, win_start_d;
   logic                busy_q,      busy_d;
   logic                xfer;
   logic                shift_en;

   assign xfer = in_valid & in_ready_q;

   always_comb begin
      state_d     = state_q;
      fill_cnt_d  = fill_cnt_q;
      new_cnt_d   = new_cnt_q;
      shift_l_d   = shift_l_q;
      win_count_d = win_count_q;
      shift_en    = 1'b0;

      if (flush) begin
         // A sample arriving with flush is dropped along with the window.
         state_d    = FILL;
         fill_cnt_d = '0;
         new_cnt_d  = '0;
      end else begin
         case (state_q)
            FILL: begin
               if (xfer) begin
                  shift_en   = 1'b1;
                  fill_cnt_d = fill_cnt_q + 1'b1;
                  if (fill_cnt_d == FILL_FULL) state_d = LAUNCH;
               end
            end
            COLLECT: begin
               if (xfer) begin
                  shift_en  = 1'b1;
                  new_cnt_d = new_cnt_q + 1'b1;
                  if (new_cnt_d == shift_l_q) state_d = LAUNCH;
               end
            end
            LAUNCH: begin
               // Clamp keeps every accepted sample inside at least one window.
               if (shift == '0)             shift_l_d = SHIFT_W'(1);
               else if (shift > SHIFT_MAX)  shift_l_d = SHIFT_MAX;
               else                         shift_l_d = shift;
               win_count_d = win_count_q + 16'd1;
               new_cnt_d   = '0;
               fill_cnt_d  = '0;
               state_d     = BUSY;
            end
            BUSY: begin
               if (win_done) state_d = COLLECT;
            end
            default: state_d = FILL;
         endcase
      end

      in_ready_d  = (state_d == FILL) || (state_d == COLLECT);
      win_start_d = (state_d == LAUNCH);
      busy_d      = (state_d == BUSY);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= FILL;
         fill_cnt_q  <= '0;
         new_cnt_q   <= '0;
         shift_l_q   <= SHIFT_W'(1);
         win_count_q <= '0;
         in_ready_q  <= 1'b0;
         win_start_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         fill_cnt_q  <= fill_cnt_d;
         new_cnt_q   <= new_cnt_d;
         shift_l_q   <= shift_l_d;
         win_count_q <= win_count_d;
         in_ready_q  <= in_ready_d;
         win_start_q <= win_start_d;
         busy_q      <= busy_d;
      end
   end

   lsr_window_sreg #(
      .DATA_SIZE (DATA_SIZE)
   ) u_sreg (
      .clk      (clk),
      .rst_n    (rst_n),
      .shift_en (shift_en),
      .din      (in_data),
      .win_flat (win_data)
   );

   assign in_ready  = in_ready_q;
   assign win_start = win_start_q;
   assign busy      = busy_q;
   assign win_count = win_count_q;

endmodule
`default_nettype wire

// File: tb/tb_lsr_window_feeder.sv
`default_nettype none
// ============================================================================
// tb_lsr_window_feeder : scenario tasks against a sample-history scoreboard
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_lsr_window_feeder;

   localparam int DS = 7;
   localparam int SW = 16;

   logic                 clk      = 1'b0;
   logic                 rst_n    = 1'b0;
   logic signed [15:0]   in_data  = '0;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic [SW-1:0]        shift    = '0;
   logic                 flush    = 1'b0;
   logic [DS*16-1:0]     win_data;
   logic                 win_start;
   logic                 win_done = 1'b0;
   logic                 busy;
   logic [15:0]          win_count;

   int checks     = 0;
   int failures   = 0;
   int n_starts   = 0;
   int exp_launch = 0;
   logic signed [15:0] hist [$];

   always #5 clk = ~clk;

   lsr_window_feeder #(.DATA_SIZE(DS), .SHIFT_W(SW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .shift     (shift),
      .flush     (flush),
      .win_data  (win_data),
      .win_start (win_start),
      .win_done  (win_done),
      .busy      (busy),
      .win_count (win_count)
   );

   // Every accepted, non-flushed sample in arrival order.
   always @(posedge clk) begin
      if (rst_n && in_valid && in_ready && !flush) hist.push_back(in_data);
   end

   always @(negedge clk) begin
      if (win_start) n_starts++;
   end

   function automatic logic [DS*16-1:0] exp_window();
      logic [DS*16-1:0] w;
      w = '0;
      for (int j = 0; j < DS; j++) begin
         if (hist.size() >= DS) w[16*j +: 16] = hist[hist.size() - DS + j];
      end
      return w;
   endfunction

   function automatic logic [DS*16-1:0] ramp(input int first);
      logic [DS*16-1:0] w;
      for (int j = 0; j < DS; j++) w[16*j +: 16] = 16'(first + j);
      return w;
   endfunction

   function automatic int clamp_shift(input int s);
      if (s == 0) return 1;
      if (s > DS) return DS;
      return s;
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Offer one sample and return one cycle after it is taken.
   task automatic send(input logic [15:0] d);
      bit got;
      got      = 1'b0;
      in_data  = d;
      in_valid = 1'b1;
      for (int c = 0; c < 50 && !got; c++) begin
         @(negedge clk);
         if (in_ready === 1'b1) begin
            @(posedge clk);
            #1;
            got = 1'b1;
         end
      end
      in_valid = 1'b0;
      checks++;
      if (!got) begin
         failures++;
         $display("FAIL send_timeout in_ready=%b required=1", in_ready);
      end
   endtask

   task automatic finish_window();
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         if (busy === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL busy_timeout busy=%b required=1", busy);
      end
      @(posedge clk); #1;
      win_done = 1'b1;
      @(posedge clk); #1;
      win_done = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step(2);
      checks += 5;
      if (in_ready !== 1'b0)  begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
      if (win_start !== 1'b0) begin failures++; $display("FAIL reset_win_start got=%b exp=0", win_start); end
      if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      if (win_count !== 16'd0) begin failures++; $display("FAIL reset_win_count got=%h exp=0", win_count); end
      if (win_data !== '0)    begin failures++; $display("FAIL reset_win_data got=%h exp=0", win_data); end
      @(negedge clk);
      rst_n = 1'b1;
      step(1);
   endtask

   task automatic test_first_window();
      int s0;
      s0    = n_starts;
      shift = 16'd2;
      for (int i = 1; i <= DS; i++) begin
         send(16'(i));
         checks++;
         if (win_start !== (i == DS)) begin
            failures++;
            $display("FAIL first_start_at_%0d got=%b exp=%b", i, win_start, (i == DS));
         end
      end
      exp_launch++;
      checks += 3;
      if (win_data !== ramp(1)) begin failures++; $display("FAIL first_window got=%h exp=%h", win_data, ramp(1)); end
      if (win_data !== exp_window()) begin failures++; $display("FAIL first_window_sb got=%h exp=%h", win_data, exp_window()); end
      if (in_ready !== 1'b0) begin failures++; $display("FAIL first_launch_ready got=%b exp=0", in_ready); end
      step(1);
      checks += 4;
      if (win_start !== 1'b0) begin failures++; $display("FAIL first_single_pulse got=%b exp=0", win_start); end
      if (busy !== 1'b1) begin failures++; $display("FAIL first_busy got=%b exp=1", busy); end
      if (win_count !== 16'(exp_launch)) begin failures++; $display("FAIL first_count got=%0d exp=%0d", win_count, exp_launch); end
      if (n_starts - s0 !== 1) begin failures++; $display("FAIL first_pulses got=%0d exp=1", n_starts - s0); end
   endtask

   task automatic test_shift2();
      in_data  = 16'd8;
      in_valid = 1'b1;
      repeat (5) begin
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_hold in_ready=%b busy=%b exp in_ready=0 busy=1", in_ready, busy);
         end
      end
      @(posedge clk); #1;
      win_done = 1'b1;
      @(posedge clk); #1;
      win_done = 1'b0;
      checks++;
      if (hist.size() !== DS) begin failures++; $display("FAIL held_sample_count got=%0d exp=%0d", hist.size(), DS); end
      shift = 16'd0;
      send(16'd8);
      checks++;
      if (win_start !== 1'b0) begin failures++; $display("FAIL shift2_early got=%b exp=0", win_start); end
      send(16'd9);
      exp_launch++;
      checks += 2;
      if (win_start !== 1'b1) begin failures++; $display("FAIL shift2_start got=%b exp=1", win_start); end
      if (win_data !== ramp(3)) begin failures++; $display("FAIL shift2_window got=%h exp=%h", win_data, ramp(3)); end
   endtask

   task automatic test_shift_clamp();
      for (int r = 0; r < 3; r++) begin
         finish_window();
         if (r == 2) shift = 16'd20;
         send(16'($urandom));
         exp_launch++;
         checks += 2;
         if (win_start !== 1'b1) begin failures++; $display("FAIL shift0_start_%0d got=%b exp=1", r, win_start); end
         if (win_data !== exp_window()) begin failures++; $display("FAIL shift0_window_%0d got=%h exp=%h", r, win_data, exp_window()); end
      end
      finish_window();
      shift = 16'd7;
      for (int i = 0; i < DS; i++) begin
         send(16'($urandom));
         checks++;
         if (win_start !== (i == DS - 1)) begin
            failures++;
            $display("FAIL shift20_start_at_%0d got=%b exp=%b", i, win_start, (i == DS - 1));
         end
      end
      exp_launch++;
      checks++;
      if (win_data !== exp_window()) begin failures++; $display("FAIL shift20_window got=%h exp=%h", win_data, exp_window()); end
   endtask

   task automatic test_flush();
      int s0;
      step(1);
      flush = 1'b1;
      step(1);
      flush = 1'b0;
      checks += 3;
      if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", busy); end
      if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_ready got=%b exp=1", in_ready); end
      if (win_count !== 16'(exp_launch)) begin failures++; $display("FAIL flush_count got=%0d exp=%0d", win_count, exp_launch); end
      s0       = n_starts;
      win_done = 1'b1;
      step(2);
      win_done = 1'b0;
      checks += 2;
      if (n_starts !== s0) begin failures++; $display("FAIL done_ignored starts=%0d exp=%0d", n_starts, s0); end
      if (in_ready !== 1'b1) begin failures++; $display("FAIL done_ignored_ready got=%b exp=1", in_ready); end
      // A sample offered together with flush must not enter the window.
      in_data  = 16'h7abc;
      in_valid = 1'b1;
      flush    = 1'b1;
      step(1);
      in_valid = 1'b0;
      flush    = 1'b0;
      for (int i = 0; i < DS; i++) begin
         send(16'($urandom));
         checks++;
         if (win_start !== (i == DS - 1)) begin
            failures++;
            $display("FAIL flush_refill_at_%0d got=%b exp=%b", i, win_start, (i == DS - 1));
         end
      end
      exp_launch++;
      checks++;
      if (win_data !== exp_window()) begin failures++; $display("FAIL flush_window got=%h exp=%h", win_data, exp_window()); end
   endtask

   task automatic test_async_reset();
      finish_window();
      for (int i = 0; i < 2; i++) begin
         send(16'($urandom));
         checks++;
         if (win_start !== 1'b0) begin failures++; $display("FAIL collect_early got=%b exp=0", win_start); end
      end
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      checks += 4;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL areset_ready got=%b exp=0", in_ready); end
      if (busy !== 1'b0) begin failures++; $display("FAIL areset_busy got=%b exp=0", busy); end
      if (win_count !== 16'd0) begin failures++; $display("FAIL areset_count got=%0d exp=0", win_count); end
      if (win_data !== '0) begin failures++; $display("FAIL areset_data got=%h exp=0", win_data); end
      @(negedge clk);
      rst_n = 1'b1;
      step(1);
      exp_launch = 0;
      for (int i = 0; i < DS; i++) begin
         send(16'($urandom));
         checks++;
         if (win_start !== (i == DS - 1)) begin
            failures++;
            $display("FAIL areset_refill_at_%0d got=%b exp=%b", i, win_start, (i == DS - 1));
         end
      end
      exp_launch++;
      checks++;
      if (win_data !== exp_window()) begin failures++; $display("FAIL areset_window got=%h exp=%h", win_data, exp_window()); end
   endtask

   task automatic test_wrap();
      step(1);
      force dut.win_count_q = 16'hFFFF;
      step(1);
      release dut.win_count_q;
      step(1);
      exp_launch = 16'hFFFF;
      checks++;
      if (win_count !== 16'hFFFF) begin failures++; $display("FAIL wrap_preset got=%h exp=ffff", win_count); end
      finish_window();
      for (int i = 0; i < DS; i++) send(16'($urandom));
      exp_launch = (exp_launch + 1) & 16'hFFFF;
      step(1);
      checks++;
      if (win_count !== 16'(exp_launch)) begin failures++; $display("FAIL wrap_count got=%h exp=%h", win_count, 16'(exp_launch)); end
   endtask

   task automatic test_random();
      int k;
      int s;
      finish_window();
      flush = 1'b1;
      step(1);
      flush = 1'b0;
      k = DS;
      for (int w = 0; w < 8; w++) begin
         s     = int'($urandom_range(0, 10));
         shift = SW'(s);
         for (int i = 0; i < k; i++) begin
            step(int'($urandom_range(0, 2)));
            send(16'($urandom));
            checks++;
            if (win_start !== (i == k - 1)) begin
               failures++;
               $display("FAIL rand_start_w%0d_s%0d got=%b exp=%b", w, i, win_start, (i == k - 1));
            end
         end
         exp_launch = (exp_launch + 1) & 16'hFFFF;
         checks++;
         if (win_data !== exp_window()) begin failures++; $display("FAIL rand_window_w%0d got=%h exp=%h", w, win_data, exp_window()); end
         step(1);
         checks++;
         if (win_count !== 16'(exp_launch)) begin failures++; $display("FAIL rand_count_w%0d got=%0d exp=%0d", w, win_count, exp_launch); end
         step(int'($urandom_range(0, 4)));
         finish_window();
         k = clamp_shift(s);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog time_limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_first_window();
      test_shift2();
      test_shift_clamp();
      test_flush();
      test_async_reset();
      test_wrap();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
